two_sum_driver: RTL and testbench
=================================

Name: two_sum_driver

Overview:
- Client-side controller for `hashmap`: it drives `hashmap`'s write and query ports and consumes its responses.
- Solves the streaming two-sum problem. For each streamed number, it queries the map for `(target - num)`. On a hit it reports both indices. On a miss it inserts the number.
- It sits between an AXI-style input stream and one external `hashmap` instance (KEY_WIDTH=DATA_WIDTH, VALUE_WIDTH=DATA_WIDTH+INDEX_WIDTH, OVERWRITE=0).

Parameters:
- DATA_WIDTH, 8, element and target width; all arithmetic is modulo 2^DATA_WIDTH.
- INDEX_WIDTH, 4, element index width; maximum list length MAX_LEN = 2^INDEX_WIDTH.
- VALUE_WIDTH, DATA_WIDTH+INDEX_WIDTH, width of the map value {num, index}; derived, not overridden.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin a new problem; sampled only in IDLE
- target  in  DATA_WIDTH  sum target; latched on start
- in_valid  in  1  stream element valid
- in_ready  out  1  stream element accepted when in_valid && in_ready
- in_data  in  DATA_WIDTH  element value
- in_last  in  1  marks final element
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle result strobe
- found  out  1  pair found (held until next start)
- idx_lo  out  INDEX_WIDTH  earlier index of pair
- idx_hi  out  INDEX_WIDTH  later index of pair
- too_long  out  1  list exceeded MAX_LEN (held until next start)
- hm_collision_seen  out  1  sticky: a map insert hit an occupied slot
- hm_write_key  out  DATA_WIDTH  = in_data
- hm_write_value  out  VALUE_WIDTH  = {in_data, idx}
- hm_write_request  out  1  insert strobe
- hm_collision  in  1  from map
- hm_read_key  out  DATA_WIDTH  = target_q - in_data (wrapping)
- hm_read_value  in  VALUE_WIDTH  from map, combinational
- hm_read_response  in  1  from map, combinational
- hm_clear_cache  out  1  map clear strobe

Behaviour:
- Reset: state=IDLE; idx=0; all outputs 0, including found, idx_lo, idx_hi, done, too_long, hm_collision_seen, hm_write_request and hm_clear_cache. Reset mid-operation aborts immediately; no done pulse is emitted.
- FSM states: IDLE, CLEAR, RUN, DRAIN, FIN.
- IDLE:
  - in_ready=0.
  - On start: latch target into target_q. Clear found, idx_lo, idx_hi, too_long and hm_collision_seen. Set idx=0. Go to CLEAR.
  - start in any other state is ignored.
- CLEAR: hm_clear_cache=1 for exactly one cycle, then go to RUN. in_ready=0.
- RUN: in_ready=1. An accepted beat is evaluated combinationally the same cycle:
  - match = hm_read_response && hm_read_value[VALUE_WIDTH-1:INDEX_WIDTH] == hm_read_key.
  - The stored num is compared so that hash-aliased slots never give false hits.
  - On match: found<=1; idx_lo<=hm_read_value[INDEX_WIDTH-1:0]; idx_hi<=idx; no write. Go to FIN if in_last, else DRAIN.
  - On no match: hm_write_request=1. Next state is:
    - FIN if in_last;
    - DRAIN with too_long<=1 if idx==MAX_LEN-1;
    - otherwise RUN with idx<=idx+1.
  - hm_write_request is never asserted without an accepted beat.
- Self-pairing is impossible: the lookup sees map state before that beat's insert, because the map write is registered.
- Sticky flag: hm_collision_seen<=1 when hm_write_request && hm_collision. Results may then be missed (first occurrence kept, OVERWRITE=0), but they are never wrong.
- DRAIN: in_ready=1. Accepted beats are discarded with no map traffic. Go to FIN on an accepted in_last.
- FIN: done=1 for one cycle, then go to IDLE. found, idx_lo, idx_hi and too_long stay stable until the next start.
- Latency: done is asserted 1 cycle after the accepted in_last beat. The result registers are valid the cycle after the matching beat.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE=0, CLEAR=1, RUN=2, DRAIN=3, FIN=4);
  - the VALUE_WIDTH derivation;
  - pack/unpack helper functions for {num, index}.
- No sub-module inside the block: `hashmap` is instantiated beside it by the integrating top.
- Bench top: tb wrapper instantiating two_sum_driver plus hashmap with CACHE_SIZE=16.

Test Plan:
- target=9, stream [2,7,11,15] -> found=1, idx_lo=0, idx_hi=1. Beats 2 and 3 are drained with no writes. done 1 cycle after the beat-3 handshake.
- target=6, stream [3,2,4] -> found=1, idx_lo=1, idx_hi=2 (never 0,0). target=6, stream [3,3] -> 0,1.
- target=4, stream [200,60] -> wraparound hit: found=1, idx 0,1. target=100, stream [1,2,3] -> found=0, done once, 3 writes.
- CACHE_SIZE=16:
  - target=34, stream [1,17] -> lookup at slot 1 returns num 1≠17, so found=0 (no false hit);
  - target=18, same stream -> found=1, idx 0,1;
  - stream [1,17,5] with target=10 -> hm_collision_seen=1.
- 17 elements with in_last only on the last, no pair, INDEX_WIDTH=4 -> too_long=1 after beat 15, beat 16 drained, found=0.
- rst asserted in RUN after 2 beats -> next cycle IDLE, all outputs 0, no done. A new start then runs cleanly, including the CLEAR pulse.

Source files
------------

// File: rtl/two_sum_driver_pkg.sv
// Shared definitions for the streaming two-sum controller: FSM encoding,
// map value width derivation and {num, index} pack/unpack helpers.
package two_sum_driver_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLEAR = 3'd1,
      RUN   = 3'd2,
      DRAIN = 3'd3,
      FIN   = 3'd4
   } state_t;

   // Helpers work on a wide carrier; callers cast to their own widths.
   localparam int PACK_W = 32;

   function automatic int calc_value_width(input int dw, input int iw);
      return dw + iw;
   endfunction

   function automatic logic [PACK_W-1:0] pack_entry(input logic [PACK_W-1:0] num,
                                                     input logic [PACK_W-1:0] idx,
                                                     input int iw);
      return (num << iw) | idx;
   endfunction

   function automatic logic [PACK_W-1:0] unpack_num(input logic [PACK_W-1:0] v,
                                                     input int iw);
      return v >> iw;
   endfunction

   function automatic logic [PACK_W-1:0] unpack_idx(input logic [PACK_W-1:0] v,
                                                     input int iw);
      return v & ((PACK_W'(1) << iw) - PACK_W'(1));
   endfunction

endpackage

// File: rtl/two_sum_driver_if.sv
// Element stream into the two-sum controller (valid/ready with last marker).
interface two_sum_driver_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_last;

   modport master (output in_valid, output in_data, output in_last, input in_ready);
   modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/two_sum_driver.sv
// Streaming two-sum controller: looks up (target - num) in an external hashmap,
// reports the index pair on a hit and inserts {num, index} on a miss.
module two_sum_driver
   import two_sum_driver_pkg::*;
#(
   parameter  int DATA_WIDTH  = 8,
   parameter  int INDEX_WIDTH = 4,
   localparam int VALUE_WIDTH = calc_value_width(DATA_WIDTH, INDEX_WIDTH)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [DATA_WIDTH-1:0]  target,
   two_sum_driver_if.slave        s,
   output logic                   busy,
   output logic                   done,
   output logic                   found,
   output logic [INDEX_WIDTH-1:0] idx_lo,
   output logic [INDEX_WIDTH-1:0] idx_hi,
   output logic                   too_long,
   output logic                   hm_collision_seen,
   output logic [DATA_WIDTH-1:0]  hm_write_key,
   output logic [VALUE_WIDTH-1:0] hm_write_value,
   output logic                   hm_write_request,
   input  logic                   hm_collision,
   output logic [DATA_WIDTH-1:0]  hm_read_key,
   input  logic [VALUE_WIDTH-1:0] hm_read_value,
   input  logic                   hm_read_response,
   output logic                   hm_clear_cache
);

   state_t                 r_state;
   logic [DATA_WIDTH-1:0]  r_target;
   logic [INDEX_WIDTH-1:0] r_idx;
   logic                   r_found;
   logic [INDEX_WIDTH-1:0] r_idx_lo;
   logic [INDEX_WIDTH-1:0] r_idx_hi;
   logic                   r_too_long;
   logic                   r_coll_seen;
   logic                   r_done;
   logic                   r_clear;

   logic                   w_accept;
   logic                   w_match;
   logic                   w_write_req;
   logic [DATA_WIDTH-1:0]  w_read_key;
   logic [DATA_WIDTH-1:0]  w_stored_num;
   logic [INDEX_WIDTH-1:0] w_stored_idx;

   assign s.in_ready   = (r_state == RUN) || (r_state == DRAIN);
   assign w_accept     = s.in_valid && s.in_ready;
   assign w_read_key   = r_target - s.in_data;
   assign w_stored_num = DATA_WIDTH'(unpack_num(PACK_W'(hm_read_value), INDEX_WIDTH));
   assign w_stored_idx = INDEX_WIDTH'(unpack_idx(PACK_W'(hm_read_value), INDEX_WIDTH));
   // Comparing the stored num rejects entries that merely share a hash slot.
   assign w_match      = hm_read_response && (w_stored_num == w_read_key);
   assign w_write_req  = (r_state == RUN) && w_accept && !w_match;

   assign hm_read_key       = w_read_key;
   assign hm_write_key      = s.in_data;
   assign hm_write_value    = VALUE_WIDTH'(pack_entry(PACK_W'(s.in_data), PACK_W'(r_idx), INDEX_WIDTH));
   assign hm_write_request  = w_write_req;
   assign hm_clear_cache    = r_clear;
   assign busy              = (r_state != IDLE);
   assign done              = r_done;
   assign found             = r_found;
   assign idx_lo            = r_idx_lo;
   assign idx_hi            = r_idx_hi;
   assign too_long          = r_too_long;
   assign hm_collision_seen = r_coll_seen;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= IDLE;
         r_idx       <= '0;
         r_found     <= 1'b0;
         r_idx_lo    <= '0;
         r_idx_hi    <= '0;
         r_too_long  <= 1'b0;
         r_coll_seen <= 1'b0;
         r_done      <= 1'b0;
         r_clear     <= 1'b0;
      end else begin
         r_done  <= 1'b0;
         r_clear <= 1'b0;
         if (w_write_req && hm_collision)
            r_coll_seen <= 1'b1;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_target    <= target;
                  r_found     <= 1'b0;
                  r_idx_lo    <= '0;
                  r_idx_hi    <= '0;
                  r_too_long  <= 1'b0;
                  r_coll_seen <= 1'b0;
                  r_idx       <= '0;
                  r_clear     <= 1'b1;
                  r_state     <= CLEAR;
               end
            end
            CLEAR: r_state <= RUN;
            RUN: begin
               if (w_accept) begin
                  if (w_match) begin
                     r_found  <= 1'b1;
                     r_idx_lo <= w_stored_idx;
                     r_idx_hi <= r_idx;
                     r_done   <= s.in_last;
                     r_state  <= s.in_last ? FIN : DRAIN;
                  end else if (s.in_last) begin
                     r_done  <= 1'b1;
                     r_state <= FIN;
                  end else if (&r_idx) begin
                     r_too_long <= 1'b1;
                     r_state    <= DRAIN;
                  end else begin
                     r_idx <= r_idx + 1'b1;
                  end
               end
            end
            DRAIN: begin
               if (w_accept && s.in_last) begin
                  r_done  <= 1'b1;
                  r_state <= FIN;
               end
            end
            FIN:     r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_two_sum_driver.sv
// Bench for two_sum_driver paired with a direct-mapped hashmap (CACHE_SIZE=16).
module hashmap #(
   parameter int KEY_WIDTH   = 8,
   parameter int VALUE_WIDTH = 12,
   parameter int CACHE_SIZE  = 16,
   parameter int OVERWRITE   = 0
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [KEY_WIDTH-1:0]   write_key,
   input  logic [VALUE_WIDTH-1:0] write_value,
   input  logic                   write_request,
   output logic                   collision,
   input  logic [KEY_WIDTH-1:0]   read_key,
   output logic [VALUE_WIDTH-1:0] read_value,
   output logic                   read_response,
   input  logic                   clear_cache
);
   localparam int SW = $clog2(CACHE_SIZE);
   logic [VALUE_WIDTH-1:0] mem [CACHE_SIZE];
   logic [CACHE_SIZE-1:0]  vld;
   logic [SW-1:0]          ws, rs;

   assign ws            = write_key[SW-1:0];
   assign rs            = read_key[SW-1:0];
   assign collision     = write_request && vld[ws];
   assign read_value    = mem[rs];
   assign read_response = vld[rs];

   always @(posedge clk) begin
      if (rst || clear_cache) begin
         vld <= '0;
      end else if (write_request && (!vld[ws] || OVERWRITE != 0)) begin
         mem[ws] <= write_value;
         vld[ws] <= 1'b1;
      end
   end
endmodule

module tb_two_sum_driver;
   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] target;
   logic       busy, done, found, too_long, hm_collision_seen;
   logic [3:0] idx_lo, idx_hi;
   logic [7:0] hm_write_key, hm_read_key;
   logic [11:0] hm_write_value, hm_read_value;
   logic       hm_write_request, hm_collision, hm_read_response, hm_clear_cache;

   int errors = 0;
   int checks = 0;
   int done_cnt = 0;
   int wr_cnt = 0;
   logic pre_done;
   logic [7:0] stim [$];

   two_sum_driver_if #(.DATA_WIDTH(8)) sif ();

   two_sum_driver #(.DATA_WIDTH(8), .INDEX_WIDTH(4)) dut (
      .clk(clk), .rst(rst), .start(start), .target(target), .s(sif),
      .busy(busy), .done(done), .found(found), .idx_lo(idx_lo), .idx_hi(idx_hi),
      .too_long(too_long), .hm_collision_seen(hm_collision_seen),
      .hm_write_key(hm_write_key), .hm_write_value(hm_write_value),
      .hm_write_request(hm_write_request), .hm_collision(hm_collision),
      .hm_read_key(hm_read_key), .hm_read_value(hm_read_value),
      .hm_read_response(hm_read_response), .hm_clear_cache(hm_clear_cache)
   );

   hashmap #(.KEY_WIDTH(8), .VALUE_WIDTH(12), .CACHE_SIZE(16), .OVERWRITE(0)) u_map (
      .clk(clk), .rst(rst), .write_key(hm_write_key), .write_value(hm_write_value),
      .write_request(hm_write_request), .collision(hm_collision),
      .read_key(hm_read_key), .read_value(hm_read_value),
      .read_response(hm_read_response), .clear_cache(hm_clear_cache)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (done) done_cnt <= done_cnt + 1;
      if (hm_write_request) wr_cnt <= wr_cnt + 1;
   end

   task automatic start_problem(input logic [7:0] t);
      start = 1'b1; target = t;
      @(posedge clk); #1;
      start = 1'b0;
      checks++; if (hm_clear_cache !== 1'b1 || busy !== 1'b1 || sif.in_ready !== 1'b0) begin
         errors++; $display("FAIL clear_enter: clear=%b busy=%b ready=%b required 1 1 0", hm_clear_cache, busy, sif.in_ready);
      end
      @(posedge clk); #1;
      checks++; if (hm_clear_cache !== 1'b0 || sif.in_ready !== 1'b1) begin
         errors++; $display("FAIL clear_exit: clear=%b ready=%b required 0 1", hm_clear_cache, sif.in_ready);
      end
   endtask

   task automatic send_beat(input logic [7:0] d, input logic last);
      bit ok = 0;
      sif.in_valid = 1'b1; sif.in_data = d; sif.in_last = last;
      for (int k = 0; k < 20; k++) begin
         if (sif.in_ready) begin
            pre_done = done;
            @(posedge clk); #1;
            ok = 1;
            break;
         end
         @(posedge clk); #1;
      end
      sif.in_valid = 1'b0; sif.in_last = 1'b0;
      checks++; if (!ok) begin
         errors++; $display("FAIL beat_timeout: data=%0d not accepted within 20 cycles", d);
      end
   endtask

   task automatic run_stim(input logic [7:0] t);
      start_problem(t);
      foreach (stim[i]) send_beat(stim[i], i == stim.size() - 1);
   endtask

   task automatic test_reset;
      checks++; if (busy !== 1'b0 || done !== 1'b0 || sif.in_ready !== 1'b0) begin
         errors++; $display("FAIL reset_ctrl: busy=%b done=%b ready=%b required 0 0 0", busy, done, sif.in_ready);
      end
      checks++; if (found !== 1'b0 || idx_lo !== 4'd0 || idx_hi !== 4'd0 || too_long !== 1'b0) begin
         errors++; $display("FAIL reset_result: found=%b lo=%0d hi=%0d too_long=%b required 0 0 0 0", found, idx_lo, idx_hi, too_long);
      end
      checks++; if (hm_collision_seen !== 1'b0 || hm_write_request !== 1'b0 || hm_clear_cache !== 1'b0) begin
         errors++; $display("FAIL reset_map: coll=%b wr=%b clr=%b required 0 0 0", hm_collision_seen, hm_write_request, hm_clear_cache);
      end
   endtask

   task automatic test_classic;
      int w0 = wr_cnt, d0 = done_cnt;
      stim = '{8'd2, 8'd7, 8'd11, 8'd15};
      run_stim(8'd9);
      checks++; if (pre_done !== 1'b0 || done !== 1'b1) begin
         errors++; $display("FAIL classic_done_latency: done at handshake=%b after=%b required 0 1", pre_done, done);
      end
      checks++; if (found !== 1'b1 || idx_lo !== 4'd0 || idx_hi !== 4'd1) begin
         errors++; $display("FAIL classic_pair: found=%b lo=%0d hi=%0d required 1 0 1", found, idx_lo, idx_hi);
      end
      checks++; if (wr_cnt - w0 !== 1) begin
         errors++; $display("FAIL classic_writes: got %0d required 1", wr_cnt - w0);
      end
      @(posedge clk); #1;
      checks++; if (done !== 1'b0 || busy !== 1'b0 || done_cnt - d0 !== 1 || found !== 1'b1) begin
         errors++; $display("FAIL classic_fin: done=%b busy=%b pulses=%0d found=%b required 0 0 1 1", done, busy, done_cnt - d0, found);
      end
   endtask

   task automatic test_self_pair;
      int w0 = wr_cnt;
      stim = '{8'd3, 8'd2, 8'd4};
      run_stim(8'd6);
      @(posedge clk); #1;
      checks++; if (found !== 1'b1 || idx_lo !== 4'd1 || idx_hi !== 4'd2 || wr_cnt - w0 !== 2) begin
         errors++; $display("FAIL self_pair_324: found=%b lo=%0d hi=%0d writes=%0d required 1 1 2 2", found, idx_lo, idx_hi, wr_cnt - w0);
      end
      stim = '{8'd3, 8'd3};
      run_stim(8'd6);
      @(posedge clk); #1;
      checks++; if (found !== 1'b1 || idx_lo !== 4'd0 || idx_hi !== 4'd1) begin
         errors++; $display("FAIL self_pair_33: found=%b lo=%0d hi=%0d required 1 0 1", found, idx_lo, idx_hi);
      end
   endtask

   task automatic test_wrap_and_miss;
      int w0, d0;
      stim = '{8'd200, 8'd60};
      run_stim(8'd4);
      @(posedge clk); #1;
      checks++; if (found !== 1'b1 || idx_lo !== 4'd0 || idx_hi !== 4'd1) begin
         errors++; $display("FAIL wrap_pair: found=%b lo=%0d hi=%0d required 1 0 1", found, idx_lo, idx_hi);
      end
      w0 = wr_cnt; d0 = done_cnt;
      stim = '{8'd1, 8'd2, 8'd3};
      run_stim(8'd100);
      @(posedge clk); #1;
      checks++; if (found !== 1'b0 || wr_cnt - w0 !== 3 || done_cnt - d0 !== 1) begin
         errors++; $display("FAIL miss_all: found=%b writes=%0d pulses=%0d required 0 3 1", found, wr_cnt - w0, done_cnt - d0);
      end
   endtask

   task automatic test_alias;
      stim = '{8'd1, 8'd17};
      run_stim(8'd34);
      @(posedge clk); #1;
      checks++; if (found !== 1'b0 || hm_collision_seen !== 1'b1) begin
         errors++; $display("FAIL alias_no_false_hit: found=%b coll=%b required 0 1", found, hm_collision_seen);
      end
      run_stim(8'd18);
      @(posedge clk); #1;
      checks++; if (found !== 1'b1 || idx_lo !== 4'd0 || idx_hi !== 4'd1 || hm_collision_seen !== 1'b0) begin
         errors++; $display("FAIL alias_true_hit: found=%b lo=%0d hi=%0d coll=%b required 1 0 1 0", found, idx_lo, idx_hi, hm_collision_seen);
      end
      stim = '{8'd1, 8'd17, 8'd5};
      run_stim(8'd10);
      @(posedge clk); #1;
      checks++; if (hm_collision_seen !== 1'b1 || found !== 1'b0) begin
         errors++; $display("FAIL collision_sticky: coll=%b found=%b required 1 0", hm_collision_seen, found);
      end
   endtask

   task automatic test_too_long;
      int w0 = wr_cnt, d0 = done_cnt;
      start_problem(8'd100);
      for (int i = 0; i < 17; i++) begin
         send_beat(8'(i + 1), i == 16);
         if (i == 14) begin
            checks++; if (too_long !== 1'b0) begin
               errors++; $display("FAIL too_long_early: got %b required 0 after beat 14", too_long);
            end
         end
         if (i == 15) begin
            checks++; if (too_long !== 1'b1 || sif.in_ready !== 1'b1) begin
               errors++; $display("FAIL too_long_set: too_long=%b ready=%b required 1 1 after beat 15", too_long, sif.in_ready);
            end
         end
      end
      @(posedge clk); #1;
      checks++; if (too_long !== 1'b1 || found !== 1'b0 || wr_cnt - w0 !== 16 || done_cnt - d0 !== 1) begin
         errors++; $display("FAIL too_long_end: too_long=%b found=%b writes=%0d pulses=%0d required 1 0 16 1", too_long, found, wr_cnt - w0, done_cnt - d0);
      end
   endtask

   task automatic test_reset_mid;
      int d0 = done_cnt;
      start_problem(8'd9);
      send_beat(8'd1, 1'b0);
      send_beat(8'd17, 1'b0);
      checks++; if (busy !== 1'b1 || hm_collision_seen !== 1'b1) begin
         errors++; $display("FAIL mid_before_rst: busy=%b coll=%b required 1 1", busy, hm_collision_seen);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      checks++; if (busy !== 1'b0 || done !== 1'b0 || sif.in_ready !== 1'b0 || hm_collision_seen !== 1'b0 || found !== 1'b0) begin
         errors++; $display("FAIL mid_rst_state: busy=%b done=%b ready=%b coll=%b found=%b required all 0", busy, done, sif.in_ready, hm_collision_seen, found);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      checks++; if (done_cnt - d0 !== 0) begin
         errors++; $display("FAIL mid_rst_no_done: pulses=%0d required 0", done_cnt - d0);
      end
      stim = '{8'd4, 8'd5};
      run_stim(8'd9);
      @(posedge clk); #1;
      checks++; if (found !== 1'b1 || idx_lo !== 4'd0 || idx_hi !== 4'd1 || done_cnt - d0 !== 1) begin
         errors++; $display("FAIL mid_restart: found=%b lo=%0d hi=%0d pulses=%0d required 1 0 1 1", found, idx_lo, idx_hi, done_cnt - d0);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; target = 8'd0;
      sif.in_valid = 1'b0; sif.in_data = 8'd0; sif.in_last = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      test_reset;
      rst = 1'b0;
      @(posedge clk); #1;
      test_classic;
      test_self_pair;
      test_wrap_and_miss;
      test_alias;
      test_too_long;
      test_reset_mid;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
